// File: rtl/mouse_pkg.sv
// Shared mouse sample definitions: default field widths, button indices and the
// packed sample layout used by the mouse event buffer and its FIFO.
package mouse_pkg;

  localparam int unsigned POS_W_DEF = 12;
  localparam int unsigned BTN_N_DEF = 3;

  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_MID   = 2;

  typedef struct packed {
    logic [POS_W_DEF-1:0] x;
    logic [POS_W_DEF-1:0] y;
    logic [BTN_N_DEF-1:0] buttons;
  } mouse_sample_t;

endpackage

// File: rtl/mouse_event_buffer_fifo.sv
// Generic first-word-fall-through FIFO with an explicit level counter.
// Pushing into a full FIFO without a pop drops the oldest entry and pulses overflow.
module sample_fifo
  import mouse_pkg::*;
#(
  parameter type         T     = mouse_sample_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   out_ready,
  output logic                   out_valid,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [LW-1:0]  level_q;
  logic           pop;
  logic           full;
  logic           drop;

  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (level_q == LW'(DEPTH));
  assign drop      = push && !pop && full;
  assign level     = level_q;
  // Head is gated so it reads zero whenever the FIFO is empty, including in reset.
  assign rdata     = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (push)
        wptr <= wptr + 1'b1;
      if (pop || drop)
        rptr <= rptr + 1'b1;
      if (push && !pop && !full)
        level_q <= level_q + 1'b1;
      else if (pop && !push)
        level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mouse_event_buffer.sv
// Mouse sample buffer: latest-sample registers, optional change-only filter and
// a drop-oldest FWFT FIFO presenting samples downstream with valid/ready.
module mouse_event_buffer
  import mouse_pkg::*;
#(
  parameter int unsigned POS_W       = POS_W_DEF,
  parameter int unsigned BTN_N       = BTN_N_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CHANGE_ONLY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [POS_W-1:0]       xpos_in,
  input  logic [POS_W-1:0]       ypos_in,
  input  logic [BTN_N-1:0]       buttons_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [POS_W-1:0]       xpos_out,
  output logic [POS_W-1:0]       ypos_out,
  output logic [BTN_N-1:0]       buttons_out,
  output logic [POS_W-1:0]       xpos_last,
  output logic [POS_W-1:0]       ypos_last,
  output logic [BTN_N-1:0]       buttons_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [BTN_N-1:0] buttons;
  } sample_t;

  sample_t in_s;
  sample_t last_s;
  sample_t head_s;
  logic    push;

  assign in_s = '{x: xpos_in, y: ypos_in, buttons: buttons_in};
  // Filter compares against the last registers before this cycle's update.
  assign push = in_valid && ((CHANGE_ONLY == 0) || (in_s != last_s));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_s <= '0;
    else if (in_valid)
      last_s <= in_s;
  end

  assign xpos_last    = last_s.x;
  assign ypos_last    = last_s.y;
  assign buttons_last = last_s.buttons;

  sample_fifo #(
    .T     (sample_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wdata     (in_s),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .rdata     (head_s),
    .level     (level),
    .overflow  (overflow)
  );

  assign xpos_out    = head_s.x;
  assign ypos_out    = head_s.y;
  assign buttons_out = head_s.buttons;

endmodule

// File: tb/tb_mouse_event_buffer.sv
// Randomised and directed bench for mouse_event_buffer across three builds,
// checked every cycle against an ordered-list model of the buffer.
module tb_mouse_event_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic [4:0]  b_in = '0;

  // dut0: defaults (12/3, DEPTH 4, change-only); dut1: 16/5, DEPTH 8, every sample;
  // dut2: 12/3, DEPTH 4, every sample.
  logic        ov0, ov1, ov2, of0, of1, of2;
  logic [11:0] xo0, yo0, xl0, yl0, xo2, yo2, xl2, yl2;
  logic [2:0]  bo0, bl0, bo2, bl2, lv0, lv2;
  logic [15:0] xo1, yo1, xl1, yl1;
  logic [4:0]  bo1, bl1;
  logic [3:0]  lv1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mouse_event_buffer dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .xpos_in(x_in[11:0]), .ypos_in(y_in[11:0]), .buttons_in(b_in[2:0]),
    .out_valid(ov0), .out_ready(out_ready),
    .xpos_out(xo0), .ypos_out(yo0), .buttons_out(bo0),
    .xpos_last(xl0), .ypos_last(yl0), .buttons_last(bl0),
    .level(lv0), .overflow(of0)
  );

  mouse_event_buffer #(.POS_W(16), .BTN_N(5), .DEPTH(8), .CHANGE_ONLY(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .xpos_in(x_in), .ypos_in(y_in), .buttons_in(b_in),
    .out_valid(ov1), .out_ready(out_ready),
    .xpos_out(xo1), .ypos_out(yo1), .buttons_out(bo1),
    .xpos_last(xl1), .ypos_last(yl1), .buttons_last(bl1),
    .level(lv1), .overflow(of1)
  );

  mouse_event_buffer #(.CHANGE_ONLY(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .xpos_in(x_in[11:0]), .ypos_in(y_in[11:0]), .buttons_in(b_in[2:0]),
    .out_valid(ov2), .out_ready(out_ready),
    .xpos_out(xo2), .ypos_out(yo2), .buttons_out(bo2),
    .xpos_last(xl2), .ypos_last(yl2), .buttons_last(bl2),
    .level(lv2), .overflow(of2)
  );

  // Model: each buffer is an ordered list, index 0 = oldest.
  logic [36:0] mq [3][8];
  int          mcnt [3];
  logic [36:0] mlast [3];
  logic        movf [3];

  function automatic int dep(input int k);
    return (k == 1) ? 8 : 4;
  endfunction

  function automatic logic [36:0] pack(input int k, input logic [15:0] x, input logic [15:0] y,
                                       input logic [4:0] b);
    if (k == 1) return {x, y, b};
    return {4'b0, x[11:0], 4'b0, y[11:0], 2'b0, b[2:0]};
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0; mlast[k] = '0; movf[k] = 1'b0;
    end
  endtask

  task automatic shift_out(input int k);
    for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
    mcnt[k]--;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [36:0] s;
      logic pop, push;
      s = pack(k, x_in, y_in, b_in);
      pop = (mcnt[k] > 0) && out_ready;
      push = in_valid && ((k != 0) || (s != mlast[k]));
      movf[k] = 1'b0;
      if (pop) shift_out(k);
      if (push) begin
        if (mcnt[k] == dep(k)) begin
          shift_out(k);
          movf[k] = 1'b1;
        end
        mq[k][mcnt[k]] = s;
        mcnt[k]++;
      end
      if (in_valid) mlast[k] = s;
    end
  endtask

  task automatic cmp(input int k, input logic ov, input logic [36:0] head, input logic [36:0] last,
                     input logic [3:0] lvl, input logic ovf);
    check($sformatf("valid%0d", k), 37'(ov), 37'(mcnt[k] > 0));
    check($sformatf("level%0d", k), 37'(lvl), 37'(mcnt[k]));
    check($sformatf("overflow%0d", k), 37'(ovf), 37'(movf[k]));
    check($sformatf("last%0d", k), last, mlast[k]);
    if (mcnt[k] > 0) check($sformatf("head%0d", k), head, mq[k][0]);
    else if (!rst) check($sformatf("head_rst%0d", k), head, '0);
  endtask

  always @(negedge clk) begin
    cmp(0, ov0, pack(0, 16'(xo0), 16'(yo0), 5'(bo0)), pack(0, 16'(xl0), 16'(yl0), 5'(bl0)), 4'(lv0), of0);
    cmp(1, ov1, pack(1, xo1, yo1, bo1), pack(1, xl1, yl1, bl1), lv1, of1);
    cmp(2, ov2, pack(2, 16'(xo2), 16'(yo2), 5'(bo2)), pack(2, 16'(xl2), 16'(yl2), 5'(bl2)), 4'(lv2), of2);
  end

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic [4:0] b, input logic rdy);
    in_valid = v; x_in = x; y_in = y; b_in = b; out_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_valid_async", 37'(ov0), '0);
    check("rst_level_async", 37'(lv0), '0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [36:0] h0();
    return pack(0, 16'(xo0), 16'(yo0), 5'(bo0));
  endfunction

  initial begin
    int early;
    logic seen_full;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    // Reset during traffic, then first push after release.
    drive(1, 16'd1, 16'd2, 5'd3, 0);
    drive(1, 16'd4, 16'd5, 5'd6, 0);
    do_reset();
    check("t1_xout_zero", 37'(xo0), '0);
    check("t1_last_zero", 37'(xl0), '0);
    drive(1, 16'd10, 16'd20, 5'd1, 0);
    check("t1_head", h0(), {4'b0, 12'd10, 4'b0, 12'd20, 2'b0, 3'd1});
    check("t1_valid", 37'(ov0), 37'd1);

    // Change-only filter.
    do_reset();
    repeat (3) drive(1, 16'd5, 16'd5, 5'd0, 0);
    drive(1, 16'd6, 16'd5, 5'd0, 0);
    check("t2_level0", 37'(lv0), 37'd2);
    check("t2_level2", 37'(lv2), 37'd4);
    check("t2_last0", pack(0, 16'(xl0), 16'(yl0), 5'(bl0)), {4'b0, 12'd6, 4'b0, 12'd5, 5'd0});
    check("t2_head_a", h0(), {4'b0, 12'd5, 4'b0, 12'd5, 5'd0});
    drive(0, 16'd0, 16'd0, 5'd0, 1);
    check("t2_head_b", h0(), {4'b0, 12'd6, 4'b0, 12'd5, 5'd0});

    // Overflow drops oldest; full push+pop keeps level.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 16'(100 + i), 16'(200 + i), 5'(i), 0);
    check("t3_ovf", 37'(of0), 37'd1);
    check("t3_level", 37'(lv0), 37'd4);
    check("t3_level1", 37'(lv1), 37'd5);
    check("t3_head", h0(), {4'b0, 12'd101, 4'b0, 12'd201, 5'd1});
    drive(0, 16'd0, 16'd0, 5'd0, 0);
    check("t3_ovf_pulse", 37'(of0), 37'd0);
    drive(1, 16'd105, 16'd205, 5'd5, 1);
    check("t4_ovf", 37'(of0), 37'd0);
    check("t4_level", 37'(lv0), 37'd4);
    check("t4_head", h0(), {4'b0, 12'd102, 4'b0, 12'd202, 5'd2});
    for (int i = 2; i < 6; i++) begin
      check("t4_pop", h0(), {4'b0, 12'(100 + i), 4'b0, 12'(200 + i), 5'(i)});
      drive(0, 16'd0, 16'd0, 5'd0, 1);
    end
    check("t4_empty", 37'(ov0), 37'd0);

    // Wide build passthrough and level reaching 8.
    do_reset();
    drive(1, 16'hFFFF, 16'h1234, 5'h1F, 0);
    check("t6_head", pack(1, xo1, yo1, bo1), {16'hFFFF, 16'h1234, 5'h1F});
    for (int i = 0; i < 8; i++) drive(1, 16'(i), 16'(i), 5'(i), 0);
    check("t6_level8", 37'(lv1), 37'd8);
    check("t6_ovf", 37'(of1), 37'd1);

    // Toggling ready with a sample every cycle.
    do_reset();
    early = 0;
    seen_full = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 16'(300 + i), 16'(i), 5'(i), 1'(i % 2 == 1));
      if (of2 && !seen_full) early++;
      if (lv2 == 3'd4) seen_full = 1'b1;
    end
    check("t5_early_ovf", 37'(early), '0);
    check("t5_full", 37'(seen_full), 37'd1);

    // Random traffic with narrow value ranges so repeats hit the filter.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      drive(1'($urandom_range(0, 9) < 7), 16'($urandom_range(0, 2)), 16'($urandom_range(0, 2)),
            5'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
